// File: rtl/alu_seq.sv
// alu_seq -- registered, handshaked ALU with a stored carry and a
// multi-cycle shift-add multiplier.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operation handshake (A, B, opcode)
//   out_valid/out_ready result handshake (Result, Z, S, C, V)
//
// Single-cycle opcodes load Result/flags on the accepting edge (latency 1).
// MUL iterates one partial product per cycle and presents its result WIDTH
// edges after the accept.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             S,
  output logic             C,
  output logic             V
);

  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_NAND = 4'b0110,
    OP_NOTA = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_SRL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_ROL  = 4'b1100,
    OP_ROR  = 4'b1101,
    OP_ADC  = 4'b1110,
    OP_MUL  = 4'b1111
  } op_e;

  state_e r_state, w_state_nxt;

  logic [WIDTH-1:0]   r_result;
  logic               r_z, r_s, r_c, r_v;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0] r_acc;

  op_e                w_op;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_mul_hi;

  assign w_op       = op_e'(opcode);
  assign w_is_mul   = (w_op == OP_MUL);
  assign in_ready   = ~rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept   = in_valid & in_ready;
  assign w_mul_last = (r_state == BUSY) && (r_cnt == LAST);
  assign out_valid  = (r_state == DONE);

  assign Result = r_result;
  assign Z      = r_z;
  assign S      = r_s;
  assign C      = r_c;
  assign V      = r_v;

  // Multiplicand shifts left, multiplier shifts right: bit 0 of r_mb always
  // selects whether the current shifted multiplicand is added.
  assign w_acc_nxt = r_acc + (r_mb[0] ? r_ma : '0);
  assign w_mul_hi  = |w_acc_nxt[2*WIDTH-1:WIDTH];

  // Single-cycle ALU datapath
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_sum = {1'b0, A} + {1'b0, B};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = ~(A[MSB] ^ B[MSB]) & (A[MSB] ^ w_res[MSB]);
      end
      OP_SUB: begin
        w_sum = {1'b0, A} - {1'b0, B};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A[MSB] ^ B[MSB]) & (A[MSB] ^ w_res[MSB]);
      end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOR:  w_res = ~(A | B);
      OP_NAND: w_res = ~(A & B);
      OP_NOTA: w_res = ~A;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: begin
        w_res = {A[WIDTH-2:0], 1'b0};
        w_c   = A[MSB];
      end
      OP_SRL: begin
        w_res = {1'b0, A[WIDTH-1:1]};
        w_c   = A[0];
      end
      OP_SRA: begin
        w_res = {A[MSB], A[WIDTH-1:1]};
        w_c   = A[0];
      end
      OP_ROL: w_res = {A[WIDTH-2:0], A[MSB]};
      OP_ROR: w_res = {A[0], A[WIDTH-1:1]};
      OP_ADC: begin
        w_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, r_carry};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = ~(A[MSB] ^ B[MSB]) & (A[MSB] ^ w_res[MSB]);
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_is_mul ? BUSY : DONE;
      BUSY: if (w_mul_last) w_state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) w_state_nxt = w_is_mul ? BUSY : DONE;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result/flag registers and stored carry.
  // Latency-1 loads mean an ADC accepted right after a load already sees the
  // updated r_carry, so no separate forwarding path is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_s      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_carry  <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_z      <= (w_res == '0);
      r_s      <= w_res[MSB];
      r_c      <= w_c;
      r_v      <= w_v;
      r_carry  <= w_c;
    end else if (w_mul_last) begin
      r_result <= w_acc_nxt[WIDTH-1:0];
      r_z      <= (w_acc_nxt[WIDTH-1:0] == '0);
      r_s      <= w_acc_nxt[MSB];
      r_c      <= w_mul_hi;
      r_v      <= w_mul_hi;
      r_carry  <= w_mul_hi;
    end
  end

  // Shift-add multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ma  <= '0;
      r_mb  <= '0;
      r_acc <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt <= '0;
      r_ma  <= {{WIDTH{1'b0}}, A};
      r_mb  <= B;
      r_acc <= '0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CW'(1);
      r_ma  <= r_ma << 1;
      r_mb  <= r_mb >> 1;
      r_acc <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Result;
  logic       Z, S, C, V;

  typedef struct {
    string      name;
    logic [7:0] r;
    logic       z, s, c, v;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Z         (Z),
    .S         (S),
    .C         (C),
    .V         (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pops the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {Result, Z, S, C, V}, 12'h000);
          n_fail += (n_chk > 0 && {Result, Z, S, C, V} == 12'h000) ? 1 : 0;
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check(e.name, {20'h0, Result, Z, S, C, V}, {20'h0, e.r, e.z, e.s, e.c, e.v});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input string name, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic push, input logic [7:0] er,
                       input logic ez, input logic es, input logic ec, input logic ev);
    int   waited;
    exp_t e;
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 32'd0, 32'd1);
    end else if (push) begin
      e.name = name; e.r = er; e.z = ez; e.s = es; e.c = ec; e.v = ev;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // After a MUL accept: count edges to out_valid, in_ready must stay low.
  task automatic mul_timing(input string name);
    int   edges;
    logic rdy_seen;
    edges    = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && edges < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({name, "_latency"}, edges, 32'd8);
    check({name, "_in_ready_busy"}, {31'd0, rdy_seen}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {20'h0, out_valid, in_ready, Result, Z, S, C, V}, 32'h0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    issue("add_7f_01", 4'b0000, 8'h7F, 8'h01, 1'b1, 8'h80, 0, 1, 0, 1);
    #1;
    check("add_latency_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    issue("sub_00_01", 4'b0001, 8'h00, 8'h01, 1'b1, 8'hFF, 0, 1, 1, 0);
    issue("slt_80_01", 4'b1000, 8'h80, 8'h01, 1'b1, 8'h01, 0, 0, 0, 0);
    issue("add_ff_01", 4'b0000, 8'hFF, 8'h01, 1'b1, 8'h00, 1, 0, 1, 0);
    issue("adc_10_20", 4'b1110, 8'h10, 8'h20, 1'b1, 8'h31, 0, 0, 0, 0);
    issue("and_f0_3c", 4'b0010, 8'hF0, 8'h3C, 1'b1, 8'h30, 0, 0, 0, 0);
    issue("sra_81",    4'b1011, 8'h81, 8'h00, 1'b1, 8'hC0, 0, 1, 1, 0);
    issue("rol_81",    4'b1100, 8'h81, 8'h00, 1'b1, 8'h03, 0, 0, 0, 0);

    issue("mul_0f_0f", 4'b1111, 8'h0F, 8'h0F, 1'b1, 8'hE1, 0, 1, 0, 0);
    mul_timing("mul_0f_0f");
    issue("mul_10_10", 4'b1111, 8'h10, 8'h10, 1'b1, 8'h00, 1, 0, 1, 1);
    mul_timing("mul_10_10");

    // Backpressure: result must freeze and further input is held off.
    out_ready = 1'b0;
    issue("add_05_03", 4'b0000, 8'h05, 8'h03, 1'b1, 8'h08, 0, 0, 0, 0);
    in_valid = 1'b1; opcode = 4'b0001; A = 8'h09; B = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_state", {18'h0, out_valid, in_ready, Result, Z, S, C, V}, {18'h0, 1'b1, 1'b0, 8'h08, 4'b0000});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue("sub_09_03", 4'b0001, 8'h09, 8'h03, 1'b1, 8'h06, 0, 0, 0, 0);

    // Produce carry_q=1 so the post-reset ADC proves it was cleared.
    issue("add_ff_02", 4'b0000, 8'hFF, 8'h02, 1'b1, 8'h01, 0, 0, 1, 0);
    issue("mul_abort", 4'b1111, 8'h0F, 8'h0F, 1'b0, 8'h00, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_mul", {20'h0, out_valid, in_ready, Result, Z, S, C, V}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      logic spurious;
      spurious = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) spurious = 1'b1;
      end
      check("no_spurious_valid", {31'd0, spurious}, 32'd0);
    end
    @(posedge clk); #1;
    issue("adc_01_01", 4'b1110, 8'h01, 8'h01, 1'b1, 8'h02, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
